// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: reset PC, NOP encoding
// and the RV32I base opcodes that if_opcode is checked against.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic [6:0] {
      OPCODE_LOAD   = 7'b0000011,
      OPCODE_OP_IMM = 7'b0010011,
      OPCODE_AUIPC  = 7'b0010111,
      OPCODE_STORE  = 7'b0100011,
      OPCODE_OP     = 7'b0110011,
      OPCODE_LUI    = 7'b0110111,
      OPCODE_BRANCH = 7'b1100011,
      OPCODE_JALR   = 7'b1100111,
      OPCODE_JAL    = 7'b1101111,
      OPCODE_SYSTEM = 7'b1110011
   } opcode_e;

   function automatic logic [6:0] opcode_of(input logic [31:0] instr);
      return instr[6:0];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the instruction buffer and
// for the shadow queue of outstanding request addresses.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_q];

   // A flush wins over anything else requested in the same cycle.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush_i) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues word fetches under a
// credit limit, buffers responses in order and handles redirects.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [6:0]      if_opcode
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = XLEN + 32;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   outstanding, fifo_count;
   logic [CW:0]     credit_used;
   logic            req_fire, rsp_keep, if_pop;
   logic            fifo_full, fifo_empty;
   logic            shadow_full, shadow_empty;
   logic [XLEN-1:0] rsp_pc;
   logic [EW-1:0]   head;
   logic            unused_bits;

   assign unused_bits = ^{redirect_pc[1:0], shadow_full, shadow_empty};

   assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

   assign if_valid  = !fifo_empty;
   assign if_pop    = if_valid && if_ready;
   assign if_pc     = head[EW-1:32];
   assign if_instr  = head[31:0];
   assign if_opcode = opcode_of(head[31:0]);

   // drop counts responses still owed for requests issued before a redirect.
   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (redirect_valid) begin
         pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
         drop_d = outstanding - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) pc_d = pc_q + XLEN'(4);
         if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= {RESET_PC[XLEN-1:2], 2'b00};
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   // The shadow queue is never flushed: its occupancy is the outstanding count.
   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_shadow (
      .clk     (clk),
      .rst     (rst),
      .push_i  (req_fire),
      .pop_i   (imem_rsp_valid),
      .flush_i (1'b0),
      .data_i  (pc_q),
      .data_o  (rsp_pc),
      .count_o (outstanding),
      .full_o  (shadow_full),
      .empty_o (shadow_empty)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_ibuf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rsp_keep),
      .pop_i   (if_pop),
      .flush_i (redirect_valid),
      .data_i  ({rsp_pc, imem_rsp_data}),
      .data_o  (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(rsp_keep && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable
// latency and a scoreboard of expected {opcode, pc, instr} per consumed word.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            if_valid;
   logic            if_ready;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc;
   logic [6:0]      if_opcode;

   int              tests = 0;
   int              fails = 0;
   int unsigned     lat = 1;
   int unsigned     cyc = 0;
   logic [31:0]     pend_addr[$];
   int unsigned     pend_due[$];
   logic [31:0]     req_log[$];
   logic [70:0]     exp_q[$];

   fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_opcode      (if_opcode)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'h0) return 32'h0020_81B3;
      return {a[24:0], 7'b0010011};
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      logic [31:0] w;
      w = memword(pc);
      exp_q.push_back({w[6:0], pc, w});
   endtask

   task automatic consume(input int k);
      int got;
      int budget;
      got = 0;
      budget = 0;
      if_ready = 1'b1;
      while (got < k && budget < 200) begin
         @(negedge clk);
         budget++;
         if (if_valid) got++;
         if (got < k) begin
            @(posedge clk);
            #1;
         end
      end
      chk("consume_count", got, k);
      @(posedge clk);
      #1;
      if_ready = 1'b0;
   endtask

   // Memory: accepts on handshake, answers in order after lat cycles.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rsp_valid = 1'b0;
         end else begin
            if (imem_rsp_valid) begin
               void'(pend_addr.pop_front());
               void'(pend_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
               pend_addr.push_back(imem_req_addr);
               pend_due.push_back(cyc + lat);
               req_log.push_back(imem_req_addr);
            end
         end
         cyc++;
         @(posedge clk);
         #1;
         if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(pend_addr[0]);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // Scoreboard consumer: every word decode accepts must be the next expected one.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && if_valid && if_ready) begin
            tests++;
            assert (exp_q.size() != 0) else begin
               fails++;
               $error("FAIL unexpected_instr: observed pc %0h expected none", if_pc);
            end
            if (exp_q.size() != 0) chk("if_stream", {if_opcode, if_pc, if_instr}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int n_log;
      int budget;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if_ready       = 1'b0;

      // Reset values
      step(2);
      @(negedge clk);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Sequential fetch with 1-cycle memory
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (!if_valid && budget < 20);
      chk("first_valid", if_valid, 1);
      chk("first_pc", if_pc, 32'h0);
      chk("opcode_rtype", if_opcode, OPCODE_OP);
      @(posedge clk);
      #1;
      expect_pc(32'h0);
      expect_pc(32'h4);
      expect_pc(32'h8);
      consume(3);
      for (int i = 0; i < 3; i++) chk("req_order", req_log[i], 32'(4 * i));

      // Decode stalled: exactly DEPTH requests beyond what was consumed
      step(4);
      @(negedge clk);
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_head_pc", if_pc, 32'hC);
      chk("stall_head_instr", if_instr, memword(32'hC));
      step(6);
      @(negedge clk);
      chk("stall_req_valid2", imem_req_valid, 0);
      chk("stall_instr_held", if_instr, memword(32'hC));
      chk("stall_req_count", req_log.size(), 5);
      chk("stall_req_last", req_log[4], 32'h10);

      // Memory not ready: request held, PC frozen
      @(posedge clk);
      #1;
      imem_req_ready = 1'b0;
      expect_pc(32'hC);
      expect_pc(32'h10);
      consume(2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", imem_req_valid, 1);
         chk("hold_addr", imem_req_addr, 32'h14);
         @(posedge clk);
         #1;
      end
      chk("hold_no_issue", req_log.size(), 5);
      imem_req_ready = 1'b1;
      expect_pc(32'h14);
      expect_pc(32'h18);
      consume(2);
      step(6);

      // Redirect with two requests in flight on a 3-cycle memory
      lat = 3;
      expect_pc(32'h1C);
      expect_pc(32'h20);
      consume(2);
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (pend_addr.size() != 2 && budget < 30);
      chk("two_in_flight", pend_addr.size(), 2);
      @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      @(negedge clk);
      chk("redir_no_req", imem_req_valid, 0);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      n_log = req_log.size();
      expect_pc(32'h100);
      expect_pc(32'h104);
      consume(2);
      chk("redir_first_addr", req_log[n_log], 32'h100);

      // Redirect in the same cycle as a response
      budget = 0;
      do begin
         @(posedge clk);
         #2;
         budget++;
      end while (!imem_rsp_valid && budget < 30);
      chk("rsp_seen", imem_rsp_valid, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      expect_pc(32'h200);
      expect_pc(32'h204);
      consume(2);
      step(15);
      @(negedge clk);
      chk("settle_drop", dut.drop_q, 0);
      chk("settle_outstanding", dut.outstanding, 0);
      chk("settle_full_valid", if_valid, 1);
      chk("settle_full_head", if_pc, 32'h208);

      // Reset while the FIFO is full
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_if_valid", if_valid, 0);
      chk("async_rst_req_valid", imem_req_valid, 0);
      step(2);
      rst = 1'b0;
      n_log = req_log.size();
      @(negedge clk);
      chk("post_rst_req_valid", imem_req_valid, 1);
      chk("post_rst_req_addr", imem_req_addr, 32'h0);
      @(posedge clk);
      #1;
      expect_pc(32'h0);
      consume(1);
      chk("post_rst_first_log", req_log[n_log], 32'h0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
